// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, per-channel debounce FSM,
// one-cycle press pulse and a sticky request held until acknowledged.
module button_conditioner #(
  parameter int unsigned NBTN            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  input  logic [NBTN-1:0] req_ack,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_rise,
  output logic [NBTN-1:0] req_pending
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0] s1_q, s2_q;
  logic [NBTN-1:0] pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < NBTN; g++) begin : g_chan
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (s2_q[g]) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[g]) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s2_q[g]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          // Level stays high while the release is being qualified.
          if (s2_q[g]) begin
            state_d = PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign btn_level[g] = level_q;
    assign btn_rise[g]  = rise_q;
  end

  // A press arriving in the same cycle as an ack takes priority, so it is never lost.
  always_comb begin
    pend_d = btn_rise | (pend_q & ~req_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign req_pending = pend_q;

endmodule
